// File: rtl/mem48_arbiter.sv
// mem48_arbiter: two-port (fetch A / data B) arbiter onto a single 48-bit memory.
// Round-robin with burst limit by default; `define MEM48_ARB_FIXED_PRIO_EN for strict B priority.
`default_nettype none

module mem48_arbiter #(
    parameter int WORDS     = 16384,
    parameter int MAX_BURST = 4,
    localparam int AW       = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req_valid,
    output logic          a_req_ready,
    input  logic          a_req_we,
    input  logic [AW-1:0] a_req_addr,
    input  logic [47:0]   a_req_wdata,
    output logic          a_rsp_valid,
    output logic [47:0]   a_rsp_rdata,
    input  logic          b_req_valid,
    output logic          b_req_ready,
    input  logic          b_req_we,
    input  logic [AW-1:0] b_req_addr,
    input  logic [47:0]   b_req_wdata,
    output logic          b_rsp_valid,
    output logic [47:0]   b_rsp_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [47:0]   mem_wdata,
    input  logic [47:0]   mem_rdata
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    port_e       owner_q, owner_d;
    logic [3:0]  burst_q, burst_d;
    logic        a_rsp_valid_q, b_rsp_valid_q;
    logic [47:0] a_rsp_rdata_q, b_rsp_rdata_q;

    port_e gnt;
    port_e other;
    logic  owner_valid, other_valid;
    logic  gnt_valid, gnt_we;
    logic  a_acc, b_acc;

    always_comb begin
        other       = port_e'(~owner_q);
        owner_valid = (owner_q == PORT_A) ? a_req_valid : b_req_valid;
        other_valid = (owner_q == PORT_A) ? b_req_valid : a_req_valid;
`ifdef MEM48_ARB_FIXED_PRIO_EN
        if (b_req_valid)      gnt = PORT_B;
        else if (a_req_valid) gnt = PORT_A;
        else                  gnt = other;
`else
        // A zero burst means the owner just idled, so contention goes to the other port.
        if (owner_valid && other_valid && burst_q == 4'd0)
            gnt = other;
        else if (owner_valid && (!other_valid || burst_q < MAX_B))
            gnt = owner_q;
        else
            gnt = other;
`endif
    end

    always_comb begin
        gnt_valid = (gnt == PORT_A) ? a_req_valid : b_req_valid;
        gnt_we    = (gnt == PORT_A) ? a_req_we    : b_req_we;
        a_acc     = gnt_valid && (gnt == PORT_A);
        b_acc     = gnt_valid && (gnt == PORT_B);
    end

    always_comb begin
        owner_d = owner_q;
        burst_d = 4'd0;
        if (gnt_valid) begin
            if (gnt == owner_q) begin
                burst_d = (burst_q == 4'd15) ? burst_q : burst_q + 4'd1;
            end else begin
                owner_d = gnt;
                burst_d = 4'd1;
            end
        end
    end

    assign a_req_ready = (gnt == PORT_A);
    assign b_req_ready = (gnt == PORT_B);
    assign mem_we      = gnt_valid && gnt_we;
    assign mem_wdata   = (gnt == PORT_A) ? a_req_wdata : b_req_wdata;

    // With nothing pending the address stays on the port that last owned the memory.
    always_comb begin
        if (a_req_valid || b_req_valid)
            mem_addr = (gnt == PORT_A) ? a_req_addr : b_req_addr;
        else
            mem_addr = (owner_q == PORT_A) ? a_req_addr : b_req_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q       <= PORT_A;
            burst_q       <= 4'd0;
            a_rsp_valid_q <= 1'b0;
            b_rsp_valid_q <= 1'b0;
            a_rsp_rdata_q <= 48'd0;
            b_rsp_rdata_q <= 48'd0;
        end else begin
            owner_q       <= owner_d;
            burst_q       <= burst_d;
            a_rsp_valid_q <= a_acc;
            b_rsp_valid_q <= b_acc;
            if (a_acc && !a_req_we) a_rsp_rdata_q <= mem_rdata;
            if (b_acc && !b_req_we) b_rsp_rdata_q <= mem_rdata;
        end
    end

    assign a_rsp_valid = a_rsp_valid_q;
    assign b_rsp_valid = b_rsp_valid_q;
    assign a_rsp_rdata = a_rsp_rdata_q;
    assign b_rsp_rdata = b_rsp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem48_arbiter.sv
// tb_mem48_arbiter: directed self-checking bench for mem48_arbiter with a small behavioural memory.
`default_nettype none

module tb_mem48_arbiter;

    localparam int WORDS = 64;
    localparam int AW    = $clog2(WORDS);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req_valid, a_req_we, b_req_valid, b_req_we;
    logic          a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
    logic [AW-1:0] a_req_addr, b_req_addr, mem_addr;
    logic [47:0]   a_req_wdata, b_req_wdata, a_rsp_rdata, b_rsp_rdata;
    logic          mem_we;
    logic [47:0]   mem_wdata, mem_rdata;
    logic [47:0]   mem [0:WORDS-1];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem48_arbiter #(.WORDS(WORDS), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic we, input logic [AW-1:0] addr, input logic [47:0] wd);
        a_req_valid = v; a_req_we = we; a_req_addr = addr; a_req_wdata = wd;
    endtask

    task automatic set_b(input logic v, input logic we, input logic [AW-1:0] addr, input logic [47:0] wd);
        b_req_valid = v; b_req_we = we; b_req_addr = addr; b_req_wdata = wd;
    endtask

    task automatic do_reset();
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 48'd0;
        do_reset();

        // Reset state: owner A, idle grant points at B.
        check("rst_a_rsp_valid", a_rsp_valid, 0);
        check("rst_b_rsp_valid", b_rsp_valid, 0);
        check("rst_a_rdata", a_rsp_rdata, 0);
        check("rst_b_rdata", b_rsp_rdata, 0);
        check("rst_b_ready", b_req_ready, 1);
        check("rst_mem_we", mem_we, 0);

        // B write then read of address 5.
        set_b(1'b1, 1'b1, 6'd5, 48'h123456789ABC);
        #1;
        check("bw_ready", b_req_ready, 1);
        check("bw_mem_we", mem_we, 1);
        check("bw_mem_addr", mem_addr, 5);
        tick();
        check("bw_rsp_valid", b_rsp_valid, 1);
        check("bw_rdata_prev", b_rsp_rdata, 0);
        set_b(1'b1, 1'b0, 6'd5, 48'd0);
        tick();
        check("br_rsp_valid", b_rsp_valid, 1);
        check("br_rdata", b_rsp_rdata, 48'h123456789ABC);
        check("br_a_rsp_quiet", a_rsp_valid, 0);
        set_b(1'b0, 1'b0, 6'd0, 48'd0);
        tick();
        check("b_rsp_pulse_end", b_rsp_valid, 0);
        check("b_rdata_hold", b_rsp_rdata, 48'h123456789ABC);

        // Reset asserted while A read response is in flight.
        set_a(1'b1, 1'b0, 6'd5, 48'd0);
        tick();
        check("ar_rsp_valid", a_rsp_valid, 1);
        check("ar_rdata", a_rsp_rdata, 48'h123456789ABC);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_a_valid", a_rsp_valid, 0);
        check("midrst_a_rdata", a_rsp_rdata, 0);
        check("midrst_b_rdata", b_rsp_rdata, 0);
        set_a(1'b0, 1'b0, 6'd0, 48'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("postrst_a_valid0", a_rsp_valid, 0);
        tick();
        check("postrst_a_valid1", a_rsp_valid, 0);

        // Simultaneous A read / B write to address 7 after reset.
        do_reset();
        set_a(1'b1, 1'b0, 6'd7, 48'd0);
        set_b(1'b1, 1'b1, 6'd7, 48'hCAFE0000BEEF);
        #1;
        check("same_b_first", b_req_ready, 1);
        check("same_a_wait", a_req_ready, 0);
        tick();
        check("same_b_rsp", b_rsp_valid, 1);
        set_b(1'b0, 1'b0, 6'd9, 48'd0);
        #1;
        check("same_a_next", a_req_ready, 1);
        tick();
        check("same_a_rsp", a_rsp_valid, 1);
        check("same_a_rdata", a_rsp_rdata, 48'hCAFE0000BEEF);

        // Idle: address follows the owner (A), no write.
        set_a(1'b0, 1'b0, 6'd7, 48'd0);
        #1;
        check("idle_mem_addr", mem_addr, 7);
        check("idle_mem_we", mem_we, 0);

`ifndef MEM48_ARB_FIXED_PRIO_EN
        // Continuous contention: runs of four, B first.
        do_reset();
        set_a(1'b1, 1'b0, 6'd1, 48'd0);
        set_b(1'b1, 1'b0, 6'd2, 48'd0);
        for (int i = 0; i < 16; i++) begin
            #1;
            check($sformatf("cont_a_ready_%0d", i), a_req_ready, ((i / 4) % 2) == 1);
            tick();
        end

        // Idle gap restarts the burst count.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            logic [8:0] a_pat;
            logic [8:0] b_pat;
            logic [8:0] exp_a;
            a_pat = 9'b111110111;
            b_pat = 9'b111100000;
            exp_a = 9'b011110111;
            set_a(a_pat[i], 1'b0, 6'd3, 48'd0);
            set_b(b_pat[i], 1'b0, 6'd4, 48'd0);
            #1;
            check($sformatf("gap_a_ready_%0d", i), a_req_ready, exp_a[i]);
            tick();
        end
`else
        // Strict priority: A starves while B is valid.
        do_reset();
        set_a(1'b1, 1'b0, 6'd1, 48'd0);
        set_b(1'b1, 1'b0, 6'd2, 48'd0);
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("prio_a_starve_%0d", i), a_req_ready, 0);
            tick();
        end
        set_b(1'b0, 1'b0, 6'd2, 48'd0);
        #1;
        check("prio_a_cycle11", a_req_ready, 1);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem48_arbiter.md
MEM48_ARBITER -- requirements
Module: mem48_arbiter

Interface
REQ-001 SHALL have parameter WORDS, default 16384, memory depth in 48-bit words; AW = $clog2(WORDS).
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum consecutive grants to one port while the other port waits (1..15).
REQ-003 SHALL have ports:
  clk  in  1  clock, all state on rising edge
  rst_n  in  1  asynchronous active-low reset
  a_req_valid  in  1  port A (fetch) request valid
  a_req_ready  out  1  port A request accepted this cycle
  a_req_we  in  1  port A write enable
  a_req_addr  in  AW  port A word index
  a_req_wdata  in  48  port A write data
  a_rsp_valid  out  1  port A response pulse
  a_rsp_rdata  out  48  port A read data
  b_req_valid / b_req_ready / b_req_we / b_req_addr / b_req_wdata / b_rsp_valid / b_rsp_rdata  same as port A, port B (data)
  mem_addr  out  AW  memory word index
  mem_we  out  1  memory write enable
  mem_wdata  out  48  memory write data
  mem_rdata  in  48  memory read data, combinational from mem_addr

Function
REQ-004 SHALL accept at most one request per cycle; a request is accepted when x_req_valid and x_req_ready are both high.
REQ-005 SHALL drive x_req_ready combinationally: high for the granted port only, independent of its own x_req_valid.
REQ-006 SHALL drive mem_addr/mem_we/mem_wdata from the granted port's request; mem_we = granted x_req_we AND x_req_valid; with no valid request, mem_we = 0 and mem_addr = last granted port's address.
REQ-007 SHALL register mem_rdata into x_rsp_rdata on accepted reads and assert x_rsp_valid for exactly one cycle, the cycle after acceptance (latency 1).
REQ-008 SHALL assert x_rsp_valid one cycle after an accepted write with x_rsp_rdata holding its previous value.
REQ-009 SHALL hold x_rsp_rdata stable between responses.
REQ-010 SHALL track owner (A/B) and burst counter (4 bits); grant goes to owner if owner is valid and (other not valid or burst < MAX_BURST).
REQ-011 SHALL otherwise grant the other port when it is valid, switching owner and setting burst to 1 on acceptance.
REQ-012 SHALL increment burst on each accepted owner request, saturating at 15; clear burst to 0 in any cycle with no accepted request.
REQ-013 SHALL, when neither port is valid, point grant at the non-owner port (fair next pick) without changing owner.
REQ-014 SHALL, on simultaneous valid with burst = 0, grant per REQ-013 selection policy (see REQ-019).
REQ-015 SHALL guarantee that a continuously valid port waits at most MAX_BURST cycles.
REQ-016 SHALL treat back-to-back accesses to the same address as independent; read-after-write sees written data (write commits on same edge read is captured after).

Reset
REQ-017 SHALL, while rst_n low, asynchronously force owner = A, burst = 0, a_rsp_valid = b_rsp_valid = 0, a_rsp_rdata = b_rsp_rdata = 0.
REQ-018 SHALL drop any in-flight response on reset assertion mid-operation; first grant after release goes to B if both valid (non-owner per REQ-013).

Configuration
REQ-019 SHALL, with macro MEM48_ARB_FIXED_PRIO_EN defined, grant port B whenever b_req_valid (strict data priority), ignoring owner/burst; without it, round-robin/burst policy of REQ-010..REQ-015 applies.

Verification
REQ-020 Reset: rst_n low mid-read -> both rsp_valid 0, rsp_rdata 0 same cycle, no response after release.
REQ-021 Single port: B writes 0x123456789ABC to addr 5, then reads addr 5 -> b_rsp_valid pulses each following cycle, read returns 0x123456789ABC.
REQ-022 Contention: A and B valid continuously, MAX_BURST = 4 -> grants alternate in runs of at most 4, neither waits more than 4 cycles.
REQ-023 Idle gap: A accepted 3 times, one idle cycle, A again -> burst restarts at 1, A granted.
REQ-024 Same cycle: A read addr 7 and B write addr 7 both valid after reset -> B granted first, A's read next returns B's data.
REQ-025 With MEM48_ARB_FIXED_PRIO_EN: B valid 10 cycles with A valid -> A starves 10 cycles, granted cycle 11.
